// File: rtl/demux16_assembler_pkg.sv
// Shared definitions for the 16-bit serial-to-parallel bit assembler and its
// select decoder.
package mux_pkg;

  localparam int DMX_WIDTH = 16;
  localparam int DMX_SEL_W = 4;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} dmx_state_t;

  function automatic logic [DMX_WIDTH-1:0] onehot(input logic [DMX_SEL_W-1:0] sel);
    logic [DMX_WIDTH-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_dec4to16.sv
// Select-to-write-enable decoder: at most one enable bit set, and only when
// the write is actually accepted.
module demux_dec4to16
  import mux_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int SEL_W = DMX_SEL_W
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_we
);

  always_comb begin
    o_we = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_we[i] = i_en && (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux16_assembler.sv
// Routes single bits into a 16-bit word (pointer or explicit select) and
// presents the word once every position has been written at least once.
module demux16_assembler
  import mux_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int SEL_W = DMX_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             auto_inc,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             clear,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel_cur
);

  dmx_state_t       r_state;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_mask;
  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out_word;
  logic             r_out_valid;

  logic             w_accept;
  logic [SEL_W-1:0] w_dest;
  logic [WIDTH-1:0] w_we;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic             w_done;

  assign in_ready  = (r_state == FILL);
  assign w_accept  = in_valid && in_ready;
  assign w_dest    = auto_inc ? r_ptr : sel_in;

  demux_dec4to16 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel (w_dest),
    .i_en  (w_accept),
    .o_we  (w_we)
  );

  // A rewrite of an already-written position sets no new mask bit, so it
  // can never complete the word by itself.
  assign w_shadow_nxt = (r_shadow & ~w_we) | (w_we & {WIDTH{in_bit}});
  assign w_done       = w_accept && (&(r_mask | w_we));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_shadow    <= '0;
      r_mask      <= '0;
      r_ptr       <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= FILL;
      r_mask      <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_shadow <= w_shadow_nxt;
            if (w_done) begin
              r_out_word  <= w_shadow_nxt;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
              r_mask      <= '0;
              r_ptr       <= '0;
            end else begin
              r_mask <= r_mask | w_we;
              if (auto_inc) r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        HOLD: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign out_word  = r_out_word;
  assign out_valid = r_out_valid;
  assign sel_cur   = r_ptr;

endmodule

// File: tb/tb_demux16_assembler.sv
// Directed bench for demux16_assembler: a position-set model checked every
// cycle, plus literal expectations for each scenario.
module tb_demux16_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_bit, in_valid, auto_inc, clear, out_ready;
  logic [3:0]  sel_in;
  logic        in_ready, out_valid;
  logic [15:0] out_word;
  logic [3:0]  sel_cur;

  int vec_cnt = 0;
  int err_cnt = 0;

  demux16_assembler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .auto_inc  (auto_inc),
    .sel_in    (sel_in),
    .clear     (clear),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_cur   (sel_cur)
  );

  always #5 clk = ~clk;

  // Model: set of written positions, pointer as an integer mod 16, and a
  // holding flag that owns the presented word.
  logic [15:0] m_shadow;
  logic [15:0] m_out;
  bit          m_written [16];
  int          m_ptr;
  bit          m_hold;

  function automatic int distinct_after(input int d);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m_written[i] || i == d) n++;
    return n;
  endfunction

  function automatic logic [15:0] merged(input int d, input logic b);
    logic [15:0] s = m_shadow;
    s[d] = b;
    return s;
  endfunction

  function automatic int dest_of();
    return auto_inc ? m_ptr : int'(sel_in);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_shadow <= '0;
      m_out    <= '0;
      m_ptr    <= 0;
      m_hold   <= 1'b0;
      for (int i = 0; i < 16; i++) m_written[i] <= 1'b0;
    end else if (clear) begin
      m_ptr  <= 0;
      m_hold <= 1'b0;
      for (int i = 0; i < 16; i++) m_written[i] <= 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_shadow <= merged(dest_of(), in_bit);
        if (distinct_after(dest_of()) == 16) begin
          m_out  <= merged(dest_of(), in_bit);
          m_hold <= 1'b1;
          m_ptr  <= 0;
          for (int i = 0; i < 16; i++) m_written[i] <= 1'b0;
        end else begin
          m_written[dest_of()] <= 1'b1;
          if (auto_inc) m_ptr <= (m_ptr + 1) % 16;
        end
      end
    end else if (out_ready) begin
      m_hold <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] mp;
    mp = m_ptr;
    check("cyc_out_valid", 32'(out_valid), 32'(m_hold));
    check("cyc_in_ready",  32'(in_ready),  32'(!m_hold));
    check("cyc_out_word",  32'(out_word),  32'(m_out));
    check("cyc_sel_cur",   32'(sel_cur),   32'(mp[3:0]));
  end

  task automatic beat(input logic b, input logic ai, input logic [3:0] s);
    in_valid = 1'b1;
    in_bit   = b;
    auto_inc = ai;
    sel_in   = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic stream_auto(input logic [15:0] w, input string name);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check({name, "_not_early"}, 32'(out_valid), 32'd0);
      beat(w[i], 1'b1, 4'd0);
    end
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; auto_inc = 1'b1;
    sel_in = '0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_word", 32'(out_word), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sel_cur", 32'(sel_cur), 32'd0);
    rst_n = 1'b1;

    // 1: auto stream, LSB first
    stream_auto(16'h3f0a, "t1");
    check("t1_valid_next_cycle", 32'(out_valid), 32'd1);
    check("t1_word", 32'(out_word), 32'h3f0a);
    check("t1_sel_cur", 32'(sel_cur), 32'd0);
    release_word();
    check("t1_ready_after_take", 32'(in_ready), 32'd1);

    // 2: explicit positions 15 down to 0
    w = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      beat(w[i], 1'b0, 4'(i));
      check("t2_sel_cur_stays0", 32'(sel_cur), 32'd0);
    end
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_word", 32'(out_word), 32'hA5C3);

    // 3: stall in HOLD with bits offered
    in_valid = 1'b1; in_bit = 1'b1; auto_inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t3_in_ready_low", 32'(in_ready), 32'd0);
      check("t3_word_held", 32'(out_word), 32'hA5C3);
      check("t3_sel_cur", 32'(sel_cur), 32'd0);
    end
    in_valid = 1'b0;
    release_word();
    check("t3_ready_back", 32'(in_ready), 32'd1);
    check("t3_valid_dropped", 32'(out_valid), 32'd0);

    // 4: rewrite position 3 before filling the rest
    beat(1'b1, 1'b0, 4'd3);
    beat(1'b0, 1'b0, 4'd3);
    for (int p = 0; p < 16; p++) begin
      if (p != 3) begin
        check("t4_not_early", 32'(out_valid), 32'd0);
        beat(1'b1, 1'b0, 4'(p));
      end
    end
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_word", 32'(out_word), 32'hFFF7);
    release_word();

    // 5: clear mid-word with a bit offered
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b1, 4'd0);
    check("t5_ptr_before_clear", 32'(sel_cur), 32'd7);
    clear = 1'b1;
    beat(1'b1, 1'b1, 4'd0);
    clear = 1'b0;
    check("t5_sel_cur_cleared", 32'(sel_cur), 32'd0);
    check("t5_valid_low", 32'(out_valid), 32'd0);
    stream_auto(16'h1234, "t5");
    check("t5_word", 32'(out_word), 32'h1234);
    release_word();

    // 6: async reset mid-fill and mid-hold
    for (int i = 0; i < 9; i++) beat(1'b1, 1'b1, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_fill_rst_sel_cur", 32'(sel_cur), 32'd0);
    check("t6_fill_rst_word", 32'(out_word), 32'd0);
    check("t6_fill_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stream_auto(16'hFFFF, "t6");
    check("t6_word", 32'(out_word), 32'hFFFF);
    check("t6_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_hold_rst_valid", 32'(out_valid), 32'd0);
    check("t6_hold_rst_word", 32'(out_word), 32'd0);
    check("t6_hold_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
